mem_bus_arbiter: RTL and testbench

//  Shares the single memory/IO bus between two masters: m0 = CPU load/store

---
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin bus arbiter with region decode, fixed wait states
// and a single response per transaction (error, read data or write ack).
module mem_bus_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MEM_WAIT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_m0_req,
    input  logic                i_m0_we,
    input  logic [31:0]         i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_bmask,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,
    output logic                o_m0_err,
    input  logic                i_m1_req,
    input  logic                i_m1_we,
    input  logic [31:0]         i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_bmask,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic                o_m1_err,
    output logic                o_s_en,
    output logic [1:0]          o_s_sel,
    output logic [2:0]          o_s_io_sel,
    output logic [31:0]         o_s_addr,
    output logic                o_s_we,
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_bmask,
    input  logic [DATA_W-1:0]   i_s_rdata
);

    localparam int BW = DATA_W / 8;
    localparam int CW = $clog2(MEM_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              last_m1;
    logic              owner;
    logic [31:0]       addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BW-1:0]     bmask;
    logic [1:0]        sel;
    logic [2:0]        io_sel;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rdata;

    logic              any_req;
    logic              pick_m1;
    logic              take;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BW-1:0]     req_bmask;
    logic [1:0]        dec_sel;
    logic [2:0]        dec_io;
    logic              dec_err;
    logic              drive;
    logic              resp;

    // Round-robin choice: on a tie the master not granted last wins.
    always_comb begin
        any_req   = i_m0_req | i_m1_req;
        pick_m1   = i_m1_req & (~i_m0_req | ~last_m1);
        take      = (state == IDLE) & any_req & i_rst_n;
        req_we    = pick_m1 ? i_m1_we    : i_m0_we;
        req_addr  = pick_m1 ? i_m1_addr  : i_m0_addr;
        req_wdata = pick_m1 ? i_m1_wdata : i_m0_wdata;
        req_bmask = pick_m1 ? i_m1_bmask : i_m0_bmask;
        o_m0_gnt  = take & ~pick_m1;
        o_m1_gnt  = take & pick_m1;
    end

    // Region decode of the winning request and access-rights check.
    always_comb begin
        dec_sel = 2'd0;
        dec_io  = 3'd0;
        case (req_addr[15:12])
            4'h0, 4'h1: dec_sel = 2'd1;
            4'h2, 4'h3: dec_sel = 2'd2;
            4'h4:       dec_sel = 2'd3;
            default:    dec_sel = 2'd0;
        endcase
        case (req_addr[15:4])
            12'h781: dec_io = 3'd1;
            12'h780: dec_io = 3'd2;
            12'h703: dec_io = 3'd3;
            12'h702: dec_io = 3'd4;
            12'h701: dec_io = 3'd5;
            12'h700: dec_io = 3'd6;
            default: dec_io = 3'd0;
        endcase
        dec_err = ((dec_sel == 2'd0) & (dec_io == 3'd0))
                | (req_we & ((dec_io == 3'd1) | (dec_io == 3'd2)))
                | (~pick_m1 & req_we & (dec_sel == 2'd1));
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) state_nxt = dec_err ? ERR : ACCESS;
            end
            ACCESS: state_nxt = WAIT;
            WAIT: begin
                if (cnt == CW'(1)) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, wait counter and read-data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_m1 <= 1'b1;
            owner   <= 1'b0;
            addr    <= '0;
            we      <= 1'b0;
            wdata   <= '0;
            bmask   <= '0;
            sel     <= '0;
            io_sel  <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else begin
            if (take) begin
                last_m1 <= pick_m1;
                owner   <= pick_m1;
                addr    <= req_addr;
                we      <= req_we;
                wdata   <= req_wdata;
                bmask   <= req_bmask;
                sel     <= dec_sel;
                io_sel  <= dec_io;
            end
            if (state == ACCESS) begin
                cnt <= (io_sel != 3'd0) ? CW'(1) : CW'(MEM_WAIT);
            end
            if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) rdata <= i_s_rdata;
            end
        end
    end

    // Bus and response outputs decoded from the current state.
    always_comb begin
        drive       = (state == ACCESS) | (state == WAIT) | (state == RESP);
        resp        = (state == RESP);
        o_s_en      = (state == ACCESS);
        o_s_sel     = drive ? sel    : '0;
        o_s_io_sel  = drive ? io_sel : '0;
        o_s_addr    = drive ? addr   : '0;
        o_s_we      = drive ? we     : 1'b0;
        o_s_wdata   = drive ? wdata  : '0;
        o_s_bmask   = drive ? bmask  : '0;
        o_m0_rvalid = (resp | (state == ERR)) & ~owner;
        o_m1_rvalid = (resp | (state == ERR)) & owner;
        o_m0_err    = (state == ERR) & ~owner;
        o_m1_err    = (state == ERR) & owner;
        o_m0_rdata  = (resp & ~we & ~owner) ? rdata : '0;
        o_m1_rdata  = (resp & ~we & owner)  ? rdata : '0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter against a
// transaction-level model of decode, access rights and latency.
module tb_mem_bus_arbiter;

    localparam int DW = 32;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0]   m0_addr = 0, m1_addr = 0;
    logic [DW-1:0] m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
    logic [3:0]    m0_bmask = 0, m1_bmask = 0;
    logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
    logic          s_en, s_we;
    logic [1:0]    s_sel;
    logic [2:0]    s_io_sel;
    logic [31:0]   s_addr;
    logic [3:0]    s_bmask;
    logic          outs_any;

    int n_chk = 0;
    int n_fail = 0;
    int io_base[6] = '{'h7810, 'h7800, 'h7030, 'h7020, 'h7010, 'h7000};

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_W(DW), .MEM_WAIT(MW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid),
        .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid),
        .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
        .o_s_en(s_en), .o_s_sel(s_sel), .o_s_io_sel(s_io_sel),
        .o_s_addr(s_addr), .o_s_we(s_we), .o_s_wdata(s_wdata),
        .o_s_bmask(s_bmask), .i_s_rdata(s_rdata)
    );

    assign outs_any = |{m0_gnt, m0_rvalid, m0_rdata, m0_err,
                        m1_gnt, m1_rvalid, m1_rdata, m1_err,
                        s_en, s_sel, s_io_sel, s_addr, s_we,
                        s_wdata, s_bmask};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: region by address ranges, peripherals by 16-byte windows.
    function automatic void ref_decode(input logic [31:0] a,
                                       output int sel, output int io);
        int lo;
        lo  = int'(a[15:0]);
        sel = 0;
        io  = 0;
        if (lo < 'h2000)      sel = 1;
        else if (lo < 'h4000) sel = 2;
        else if (lo < 'h5000) sel = 3;
        for (int i = 0; i < 6; i++)
            if (lo >= io_base[i] && lo < io_base[i] + 16) io = i + 1;
    endfunction

    task automatic set_m(input int m, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] bm);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a;
            m0_wdata = wd; m0_bmask = bm;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a;
            m1_wdata = wd; m1_bmask = bm;
        end
    endtask

    task automatic do_txn(input int m, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] bm,
                          input logic [31:0] rd);
        int sel, io, rv_at, samp, w;
        int en_n, en_k, rv_n, rv_k, oth_rv;
        logic err;
        logic [31:0] rv_data, c_addr, c_wdata;
        logic rv_err, c_we;
        logic [1:0] c_sel;
        logic [2:0] c_io;
        logic [3:0] c_bm;
        ref_decode(a, sel, io);
        err = (sel == 0 && io == 0) || (we && (io == 1 || io == 2))
            || (m == 0 && we && sel == 1);
        rv_at = err ? 1 : (io != 0 ? 3 : 2 + MW);
        samp  = rv_at - 1;
        set_m(m, 1'b1, we, a, wd, bm);
        w = 0;
        @(negedge clk);
        while (!(m == 0 ? m0_gnt : m1_gnt) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("gnt", m == 0 ? m0_gnt : m1_gnt, 1);
        check("gnt_other", m == 0 ? m1_gnt : m0_gnt, 0);
        en_n = 0; en_k = 0; rv_n = 0; rv_k = 0; oth_rv = 0;
        rv_data = 0; rv_err = 0; c_addr = 0; c_wdata = 0;
        c_we = 0; c_sel = 0; c_io = 0; c_bm = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) set_m(m, 1'b0, we, a, wd, bm);
            s_rdata = (k == samp) ? rd : $urandom;
            @(negedge clk);
            if (s_en) begin
                en_n++; en_k = k;
                c_sel = s_sel; c_io = s_io_sel; c_addr = s_addr;
                c_we = s_we; c_wdata = s_wdata; c_bm = s_bmask;
            end
            if (m == 0 ? m0_rvalid : m1_rvalid) begin
                rv_n++; rv_k = k;
                rv_data = m == 0 ? m0_rdata : m1_rdata;
                rv_err  = m == 0 ? m0_err : m1_err;
            end
            if (m == 0 ? m1_rvalid : m0_rvalid) oth_rv++;
        end
        check($sformatf("en_cnt@%h", a), en_n, err ? 0 : 1);
        check("rv_cnt", rv_n, 1);
        check($sformatf("rv_cycle@%h", a), rv_k, rv_at);
        check("rv_err", rv_err, err);
        check("rv_data", rv_data, (err || we) ? 0 : rd);
        check("other_rv", oth_rv, 0);
        if (!err) begin
            check("en_cycle", en_k, 1);
            check("s_sel", c_sel, sel);
            check("s_io_sel", c_io, io);
            check("s_addr", c_addr, a);
            check("s_we", c_we, we);
            check("s_wdata", c_wdata, wd);
            check("s_bmask", c_bm, bm);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    logic [31:0] tbl[15] = '{'h2004, 'h0010, 'h1ffc, 'h3000, 'h4000,
                             'h4ffc, 'h5000, 'h7810, 'h7800, 'h7000,
                             'h7030, 'h7020, 'h7010, 'h7040, 'h8000};

    initial begin
        int g, cyc, both, rv0, rv1;
        logic [31:0] a, r;
        // reset held with random requests
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            m0_req = 1'(($urandom % 2)); m1_req = 1'(($urandom % 2));
            m0_addr = $urandom; m1_addr = $urandom;
            m0_we = 1'(($urandom % 2)); m1_we = 1'(($urandom % 2));
            @(negedge clk);
            check("rst_outs", outs_any, 0);
        end
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_outs", outs_any, 0);
        end

        do_txn(0, 0, 32'h2004, 0, 4'hf, 32'hdeadbeef);
        do_txn(0, 1, 32'h0010, 32'h1111, 4'hf, 32'h5);
        do_txn(1, 1, 32'h0010, 32'h12345678, 4'h3, 32'h6);
        do_txn(0, 1, 32'h7800, 32'h1, 4'h1, 32'h7);
        do_txn(0, 0, 32'h7810, 0, 4'hf, 32'h0000000b);
        do_txn(0, 1, 32'h7000, 32'h55, 4'h1, 32'h8);
        do_txn(0, 0, 32'h5000, 0, 4'hf, 32'h9);

        // both masters requesting: alternate starting at m0
        pulse_reset();
        s_rdata = 32'hcafef00d;
        set_m(0, 1, 0, 32'h2000, 0, 4'hf);
        set_m(1, 1, 0, 32'h3010, 0, 4'hf);
        g = 0; cyc = 0; both = 0; rv0 = 0; rv1 = 0;
        while (g < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m0_rvalid && m1_rvalid) both++;
            if (m0_rvalid) begin
                rv0++;
                check("rr_rdata0", m0_rdata, 32'hcafef00d);
            end
            if (m1_rvalid) begin
                rv1++;
                check("rr_rdata1", m1_rdata, 32'hcafef00d);
            end
            if (m0_gnt || m1_gnt) begin
                check("rr_one_gnt", m0_gnt & m1_gnt, 0);
                check("rr_order", m1_gnt, g % 2);
                g++;
                if (g == 4) begin
                    @(posedge clk); #1;
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        check("rr_grants", g, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_rvalid && m1_rvalid) both++;
            if (m0_rvalid) rv0++;
            if (m1_rvalid) rv1++;
            check("rr_no_gnt", m0_gnt | m1_gnt, 0);
        end
        check("rr_rv0", rv0, 2);
        check("rr_rv1", rv1, 2);
        check("rr_both", both, 0);

        // reset in the middle of a DMEM read wait
        set_m(0, 1, 0, 32'h2004, 0, 4'hf);
        cyc = 0;
        @(negedge clk);
        while (!m0_gnt && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_gnt", m0_gnt, 1);
        @(posedge clk); #1 m0_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("mid_rst_outs", outs_any, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        rv0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) rv0++;
        end
        check("mid_no_rv", rv0, 0);
        do_txn(1, 0, 32'h2008, 0, 4'hf, 32'h0badf00d);

        // randomized single-master traffic
        for (int i = 0; i < 40; i++) begin
            a = tbl[$urandom % 15];
            if ($urandom % 4 == 0) a = $urandom;
            a = ($urandom & 32'hffff0000) | (a & 32'h0000ffff);
            r = $urandom;
            do_txn(int'($urandom % 2), 1'(($urandom % 2)), a, $urandom,
                   4'(($urandom % 16)), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
